// File: rtl/clk_div_bank.sv
// clk_div_bank: N_CH independent clock dividers with shadowed divisor/mode and global sync
module clk_div_bank #(
    parameter int N_CH   = 4,
    parameter int DIV_WD = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [N_CH-1:0]        en_i,
    input  logic                   sync_i,
    input  logic [N_CH-1:0]        mode_i,
    input  logic [N_CH*DIV_WD-1:0] div_i,
    output logic [N_CH-1:0]        clk_o,
    output logic [N_CH-1:0]        tick_o,
    output logic [N_CH-1:0]        run_o
);
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [DIV_WD-1:0] cnt, cur_div, div;
        logic              cur_mode, run, clk_q, tick_q;
        assign div = div_i[k*DIV_WD +: DIV_WD];
        // channel state: disable, (re)start or sync, park on zero divisor, count, period event
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt      <= '0;
                cur_div  <= '0;
                cur_mode <= 1'b0;
                run      <= 1'b0;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else if (!en_i[k]) begin
                run    <= 1'b0;
                cnt    <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else if (!run || sync_i || cur_div == '0) begin
                run      <= 1'b1;
                cnt      <= '0;
                cur_div  <= div;
                cur_mode <= mode_i[k];
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else if (cnt == cur_div - DIV_WD'(1)) begin
                cnt      <= '0;
                cur_div  <= div;
                cur_mode <= mode_i[k];
                clk_q    <= mode_i[k] | ~clk_q;
                tick_q   <= mode_i[k] | ~clk_q;
            end else begin
                cnt    <= cnt + DIV_WD'(1);
                clk_q  <= clk_q & ~cur_mode;
                tick_q <= 1'b0;
            end
        end
        assign clk_o[k]  = clk_q;
        assign tick_o[k] = tick_q;
        assign run_o[k]  = run;
    end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed checks of the clock divider bank
module tb_clk_div_bank;
    localparam int N_CH = 4, DIV_WD = 16;
    logic                   clk_i = 1'b0, rst_ni = 1'b0, sync_i = 1'b0;
    logic [N_CH-1:0]        en_i, mode_i, clk_o, tick_o, run_o;
    logic [N_CH*DIV_WD-1:0] div_i;
    int checks = 0, failures = 0;
    logic [15:0] v0, t0, v1, t1, v2;
    int n;

    clk_div_bank #(.N_CH(N_CH), .DIV_WD(DIV_WD)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .sync_i(sync_i),
        .mode_i(mode_i), .div_i(div_i), .clk_o(clk_o), .tick_o(tick_o), .run_o(run_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int cnt);
        repeat (cnt) @(posedge clk_i);
        #1;
    endtask

    task automatic set_div(input int k, input logic [DIV_WD-1:0] d);
        div_i[k*DIV_WD +: DIV_WD] = d;
    endtask

    initial begin
        en_i = '1; mode_i = '0;
        div_i = {4{16'd3}};
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_clk", 32'(clk_o), 0);
        check("rst_tick", 32'(tick_o), 0);
        check("rst_run", 32'(run_o), 0);
        rst_ni = 1'b1;
        step(1);
        check("run_after_rst", 32'(run_o), 32'hF);
        en_i = '0;
        step(1);
        check("run_dis", 32'(run_o), 0);

        en_i = 4'b0011; mode_i = 4'b0010;
        set_div(0, 3); set_div(1, 4);
        for (int e = 0; e < 16; e++) begin
            step(1);
            v0[e] = clk_o[0]; t0[e] = tick_o[0]; v1[e] = clk_o[1]; t1[e] = tick_o[1];
        end
        check("sq3_clk", 32'(v0), 32'h8E38);
        check("sq3_tick", 32'(t0), 32'h8208);
        check("st4_clk", 32'(v1), 32'h1110);
        check("st4_tick", 32'(t1), 32'h1110);
        check("run_idle_ch", 32'(run_o), 32'h3);

        en_i[1] = 1'b0;
        step(1);
        set_div(1, 1); en_i[1] = 1'b1;
        step(1);
        for (int e = 0; e < 4; e++) begin
            step(1);
            v1[e] = clk_o[1]; t1[e] = tick_o[1];
        end
        check("st1_clk", 32'(v1[3:0]), 32'hF);
        check("st1_tick", 32'(t1[3:0]), 32'hF);

        en_i[0] = 1'b0; mode_i = 4'b0000;
        step(1);
        set_div(0, 5); en_i[0] = 1'b1;
        v0 = '0;
        for (int e = 0; e < 13; e++) begin
            step(1);
            v0[e] = clk_o[0];
            if (e == 1) set_div(0, 2);
        end
        check("shadow_clk", 32'(v0), 32'h0660);

        set_div(0, 2); set_div(1, 8);
        en_i = '0;
        step(1);
        en_i = 4'b0011;
        step(6);
        sync_i = 1'b1;
        step(1);
        sync_i = 1'b0;
        check("sync_clk0", 32'({clk_o[1:0], tick_o[1:0]}), 0);
        for (int e = 0; e < 16; e++) begin
            step(1);
            v0[e] = clk_o[0]; v1[e] = clk_o[1]; v2[e] = clk_o[2];
        end
        check("sync_ch0", 32'(v0), 32'h6666);
        check("sync_ch1", 32'(v1), 32'h7F80);
        check("sync_ch2", 32'(v2), 0);
        check("sync_run2", 32'(run_o[2]), 0);

        en_i = '0;
        step(1);
        set_div(0, 0); en_i = 4'b0001;
        step(1);
        v0 = '0;
        for (int e = 0; e < 5; e++) begin
            step(1);
            v0[e] = clk_o[0];
        end
        check("d0_clk", 32'(v0), 0);
        check("d0_run", 32'(run_o[0]), 1);
        set_div(0, 2);
        v0 = '0;
        for (int e = 0; e < 3; e++) begin
            step(1);
            v0[e] = clk_o[0];
        end
        check("d0_restart", 32'(v0[2:0]), 32'h4);
        en_i = '0;
        step(1);
        check("drop_clk", 32'(clk_o[0]), 0);
        check("drop_tick", 32'(tick_o[0]), 0);
        check("drop_run", 32'(run_o[0]), 0);

        set_div(3, 16'hFFFF); mode_i = 4'b1000; en_i = 4'b1000;
        step(1);
        n = 0;
        do begin
            step(1);
            n++;
        end while (!clk_o[3] && n < 70000);
        check("full_latency", 32'(n), 65535);
        check("full_tick", 32'(tick_o[3]), 1);
        step(1);
        check("full_low", 32'(clk_o[3]), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Multi-channel, parametrised successor to the single-channel clock scaler.
- Each of N_CH channels divides clk_i by its own runtime divisor.
- Each channel produces either a 50%-duty square output or a single-cycle strobe, plus a rising-edge tick.
- Divisor and mode are shadowed and updated only at period boundaries (glitch-free). A global sync re-aligns all channels, e.g. for audio BCLK/LRCLK/MCLK enables.

Parameters:
- N_CH, 4, number of independent divider channels (>=1).
- DIV_WD, 16, width of each channel divisor.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low; clock clk_i.
- en_i  in  N_CH  per-channel run enable, level.
- sync_i  in  1  global synchronous restart of all enabled channels.
- mode_i  in  N_CH  per-channel mode: 0 = square, 1 = strobe.
- div_i  in  N_CH*DIV_WD  divisors, channel k at bits [k*DIV_WD +: DIV_WD].
- clk_o  out  N_CH  divided output per channel (registered).
- tick_o  out  N_CH  one-cycle pulse coincident with each clk_o 0->1 transition (registered).
- run_o  out  N_CH  channel running flag.

Behaviour:
- Per-channel state: cnt (DIV_WD), cur_div (DIV_WD), cur_mode, run, clk_o, tick_o.
- Reset: all of the above 0, so every output is 0. Reset is honoured mid-count; no output glitch is required beyond going to 0.
- Priority at each clk_i edge, per channel: en_i low > start > sync_i > cur_div==0 > count/event.
- en_i[k]=0: run, cnt, clk_o, tick_o <= 0. cur_div and cur_mode are don't-care.
- Start (en_i[k]=1, run=0): run<=1, cnt<=0, cur_div<=div_i[k], cur_mode<=mode_i[k], clk_o<=0, tick_o<=0.
- sync_i=1 while run=1: same as start (reload div/mode, cnt<=0, outputs 0). Channels with en_i low are unaffected.
- cur_div==0 while running: cnt<=0, clk_o<=0, tick_o<=0, and cur_div/cur_mode re-sample div_i/mode_i every cycle until non-zero. A zero divisor parks the channel.
- Count, when cnt != cur_div-1: cnt<=cnt+1. clk_o holds in square mode; clk_o<=0 in strobe mode. tick_o<=0.
- Event, when cnt == cur_div-1:
  - cnt<=0, and cur_div/cur_mode reload from the inputs. This is the only point new values take effect while running.
  - Square mode: clk_o<=~clk_o; tick_o<=1 iff the new clk_o is 1.
  - Strobe mode: clk_o<=1, tick_o<=1.
- Resulting periods for D = cur_div:
  - Square: period 2*D clk_i cycles, high D, low D. D=1 gives clk_i/2.
  - Strobe: period D, high 1 cycle. D=1 gives clk_o held at 1, with tick_o 1 every cycle.
- First event latency: D edges after the start/sync edge. In square mode the first rising clk_o appears at that edge.
- Mode change at an event edge: the new mode's output rule applies from that edge, with clk_o computed from its current value.
- Counter arithmetic is DIV_WD wide. cnt never exceeds cur_div-1, so no wrap. The full-scale divisor 2^DIV_WD-1 is valid.
- No combinational path from inputs to outputs. All outputs are registered.

Test Plan:
- Reset/idle: rst_ni low 3 cycles with en_i=all 1 -> clk_o=tick_o=run_o=0; after release, run_o=1 one edge later.
- Square divide: ch0 D=3, mode 0, en rises at edge 0 -> clk_o rises at edge 3, falls at edge 6, period 6; tick_o high only the cycles after edges 3, 9, 15.
- Strobe divide: ch1 D=4, mode 1 -> clk_o=tick_o high for 1 cycle every 4 cycles, first after edge 4. D=1 -> clk_o constantly 1.
- Shadow update: ch0 D=5 running, change div_i to 2 at mid-count (cnt=1) -> the current half-period still lasts 5 cycles; following half-periods last 2.
- Global sync: ch0 D=2 square, ch1 D=8 square, pulse sync_i at an arbitrary edge -> both clk_o at 0 next cycle; ch0 rises 2 edges and ch1 rises 8 edges after the sync edge, phase-aligned thereafter. A disabled ch2 stays 0.
- Boundaries: D=0 -> clk_o stays 0 and run_o=1; writing D=2 restarts with first event 2 edges after cur_div loads. en_i dropped mid-period -> outputs 0 next edge. Full-scale D=16'hFFFF strobe -> period 65535 cycles.
